// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one shift step per clock
// Ports: clk/reset (sync, active-high); start+op+a+b launch an operation; hi_we/lo_we/wdata
// write HI/LO when idle; busy marks an operation in flight; done pulses when a result lands in hi/lo.
module mult_div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
    logic                 neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
    logic                 sa, sb;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       sum, shl, diff;
    logic [2*WIDTH-1:0]   prod;

    // Signed ops (op[0]==0) work on magnitudes; signs are reapplied in FIX.
    assign sa    = ~op[0] & a[WIDTH-1];
    assign sb    = ~op[0] & b[WIDTH-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;
    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & m_q};
    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    assign shl   = {rem_q, acc_q[WIDTH-1]};
    assign diff  = shl - {1'b0, m_q};
    assign prod  = neg_q ? -acc_q : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                    m_d     = op[1] ? abs_b : abs_a;
                    rem_d   = '0;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    dz_d    = (b == '0);
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            RUN: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
                if (op_q[1]) begin
                    rem_d            = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
                    acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    // Divide by zero already leaves |a| in rem; re-signing it restores a exactly.
                    lo_d = dz_q ? {WIDTH{1'b1}} : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    hi_d = rneg_q ? -rem_q : rem_q;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of 32- and 8-bit mult_div_unit against a transaction model
module tb_mult_div_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy32, done32, busy8, done8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    int          total = 0, bad = 0;
    bit          chk_en = 1'b0;
    int          wid [2] = '{32, 8};
    int          m_cnt [2];
    logic [31:0] m_hi [2], m_lo [2], p_hi [2], p_lo [2];
    logic        m_done [2];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata[7:0]),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    function automatic logic busy_of(input int d);
        return d == 1 ? busy8 : busy32;
    endfunction
    function automatic logic done_of(input int d);
        return d == 1 ? done8 : done32;
    endfunction
    function automatic logic [31:0] hi_of(input int d);
        return d == 1 ? {24'b0, hi8} : hi32;
    endfunction
    function automatic logic [31:0] lo_of(input int d);
        return d == 1 ? {24'b0, lo8} : lo32;
    endfunction

    function automatic logic [31:0] msk(input logic [31:0] v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return v & m[31:0];
    endfunction

    // Architectural result of one operation at width w, from plain integer arithmetic.
    function automatic logic [63:0] refop(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
        logic [63:0] mk, ux, uy, p, rh, rl;
        longint      sx, sy;
        mk = (64'd1 << w) - 64'd1;
        ux = {32'b0, x} & mk;
        uy = {32'b0, y} & mk;
        sx = longint'(ux << (64 - w)) >>> (64 - w);
        sy = longint'(uy << (64 - w)) >>> (64 - w);
        p  = (o == 2'd0) ? 64'(sx * sy) : ux * uy;
        if (!o[1]) begin
            rh = (p >> w) & mk;
            rl = p & mk;
        end else if (uy == 64'd0) begin
            rh = ux;
            rl = mk;
        end else if (o == 2'd2) begin
            rh = 64'(sx % sy) & mk;
            rl = 64'(sx / sy) & mk;
        end else begin
            rh = ux % uy;
            rl = ux / uy;
        end
        return {rh[31:0], rl[31:0]};
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0080;
            4: return 32'($urandom_range(0, 15));
            5: return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted start yields its result WIDTH+1 edges later.
    always @(posedge clk) begin
        logic [63:0] r;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_cnt[d]  = 0;
                m_hi[d]   = '0;
                m_lo[d]   = '0;
                m_done[d] = 1'b0;
            end else begin
                m_done[d] = 1'b0;
                if (m_cnt[d] > 0) begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        m_hi[d]   = p_hi[d];
                        m_lo[d]   = p_lo[d];
                        m_done[d] = 1'b1;
                    end
                end else if (start) begin
                    r        = refop(op, a, b, wid[d]);
                    p_hi[d]  = r[63:32];
                    p_lo[d]  = r[31:0];
                    m_cnt[d] = wid[d] + 1;
                end else begin
                    if (hi_we) m_hi[d] = msk(wdata, wid[d]);
                    if (lo_we) m_lo[d] = msk(wdata, wid[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk(d == 1 ? "w8 busy" : "w32 busy", 32'(busy_of(d)), 32'(m_cnt[d] > 0));
                chk(d == 1 ? "w8 done" : "w32 done", 32'(done_of(d)), 32'(m_done[d]));
                chk(d == 1 ? "w8 hi" : "w32 hi", hi_of(d), m_hi[d]);
                chk(d == 1 ? "w8 lo" : "w32 lo", lo_of(d), m_lo[d]);
            end
        end
    end

    task automatic idle_wait();
        int n = 0;
        while ((busy32 || busy8) && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic go(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el, input int ebusy, input string nm);
        int n = 0, bc = 0;
        idle_wait();
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        while (!done_of(d) && n < 200) begin
            if (busy_of(d)) bc++;
            n++;
            @(negedge clk);
        end
        chk({nm, " done"}, 32'(done_of(d)), 32'd1);
        chk({nm, " hi"}, hi_of(d), eh);
        chk({nm, " lo"}, lo_of(d), el);
        if (ebusy > 0) chk({nm, " busy cycles"}, 32'(bc), 32'(ebusy));
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        chk("reset hi", hi32, 32'h0);
        chk("reset lo", lo32, 32'h0);
        chk("reset busy", 32'(busy32), 32'h0);
        chk("reset done", 32'(done32), 32'h0);
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        go(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu max");
        go(0, 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, "mult -3*5");
        go(0, 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div -7/2");
        go(0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, "div min/-1");
        go(0, 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0, "divu 100/7");
        go(0, 2'd3, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 33, "divu by 0");
        go(0, 2'd2, 32'h8000_0001, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, 0, "div neg by 0");
        // start and MTHI while busy are ignored
        idle_wait();
        start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'hAAAA;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        dn = 0;
        while (!done32 && dn < 200) begin
            dn++;
            @(negedge clk);
        end
        chk("busy-ignore hi", hi32, 32'h0);
        chk("busy-ignore lo", lo32, 32'd42);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi", hi32, 32'h5);
        chk("mtlo", lo32, 32'h5);
        // reset mid-operation aborts
        idle_wait();
        start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'hFEDC_BA98;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort hi", hi32, 32'h0);
        chk("abort lo", lo32, 32'h0);
        chk("abort busy", 32'(busy32), 32'h0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) dn++;
        end
        chk("abort no done", 32'(dn), 32'h0);
        go(0, 2'd1, 32'd3, 32'd4, 32'h0, 32'd12, 0, "multu 3*4");
        go(1, 2'd0, 32'h80, 32'h80, 32'h40, 32'h00, 9, "w8 mult min*min");
        go(1, 2'd2, 32'h80, 32'hFF, 32'h00, 32'h80, 9, "w8 div min/-1");
        // random traffic; both widths share the stimulus and the model tracks each independently
        repeat (40000) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = rv();
            b     = rv();
            hi_we = ($urandom_range(0, 7) == 0);
            lo_we = ($urandom_range(0, 7) == 0);
            wdata = $urandom();
            reset = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
        idle_wait();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
